// File: rtl/i2c_wb_arbiter.sv
// Two-port wishbone arbiter in front of the I2C master core register port.
// Whole-transaction grants, round-robin priority, and revocation of a hung grant.
module i2c_wb_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] m0_adr_i,
    input  logic [7:0] m0_dat_i,
    output logic [7:0] m0_dat_o,
    input  logic       m0_we_i,
    input  logic       m0_stb_i,
    input  logic       m0_cyc_i,
    output logic       m0_ack_o,
    input  logic [2:0] m1_adr_i,
    input  logic [7:0] m1_dat_i,
    output logic [7:0] m1_dat_o,
    input  logic       m1_we_i,
    input  logic       m1_stb_i,
    input  logic       m1_cyc_i,
    output logic       m1_ack_o,
    output logic [2:0] s_adr_o,
    output logic [7:0] s_dat_o,
    input  logic [7:0] s_dat_i,
    output logic       s_we_o,
    output logic       s_stb_o,
    output logic       s_cyc_o,
    input  logic       s_ack_i,
    output logic [1:0] grant,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

    state_t      state, state_next;
    logic        last_owner, last_owner_next;
    logic        block0, block0_next;
    logic        block1, block1_next;
    logic [15:0] counter, counter_next;
    logic        timeout_next;

    logic eligible0, eligible1;
    logic own_idx, own_cyc, own_stb;
    logic sel0, sel1;

    assign eligible0 = m0_cyc_i & ~block0;
    assign eligible1 = m1_cyc_i & ~block1;
    assign own_idx   = (state == OWN1);
    assign own_cyc   = own_idx ? m1_cyc_i : m0_cyc_i;
    assign own_stb   = own_idx ? m1_stb_i : m0_stb_i;

    // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latches).
    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        block0_next     = block0 & m0_cyc_i;
        block1_next     = block1 & m1_cyc_i;
        counter_next    = 16'd0;
        timeout_next    = 1'b0;

        case (state)
            IDLE: begin
                if (eligible0 && eligible1)
                    state_next = last_owner ? OWN0 : OWN1;
                else if (eligible0)
                    state_next = OWN0;
                else if (eligible1)
                    state_next = OWN1;
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    last_owner_next = own_idx;
                    state_next      = GAP;
                end else if (own_stb || s_ack_i) begin
                    counter_next = 16'd0;
                end else if (counter == TIMEOUT_CYC - 16'd1) begin
                    // Hung owner: revoke and keep it out until it drops cyc.
                    timeout_next    = 1'b1;
                    last_owner_next = own_idx;
                    state_next      = GAP;
                    if (own_idx)
                        block1_next = 1'b1;
                    else
                        block0_next = 1'b1;
                end else begin
                    counter_next = counter + 16'd1;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            block0     <= 1'b0;
            block1     <= 1'b0;
            counter    <= 16'd0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            block0     <= block0_next;
            block1     <= block1_next;
            counter    <= counter_next;
            timeout    <= timeout_next;
        end
    end

    // Outputs are forced quiet while reset is held, even before the state register clears.
    assign sel0  = (state == OWN0) && !rst;
    assign sel1  = (state == OWN1) && !rst;
    assign grant = {sel1, sel0};

    always_comb begin
        s_adr_o  = 3'd0;
        s_dat_o  = 8'd0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_dat_o = 8'd0;
        m1_ack_o = 1'b0;
        m1_dat_o = 8'd0;
        if (sel0) begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_stb_o  = m0_stb_i;
            s_cyc_o  = m0_cyc_i;
            m0_ack_o = s_ack_i;
            m0_dat_o = s_dat_i;
        end else if (sel1) begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_stb_o  = m1_stb_i;
            s_cyc_o  = m1_cyc_i;
            m1_ack_o = s_ack_i;
            m1_dat_o = s_dat_i;
        end
    end

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Bench for i2c_wb_arbiter: directed vector table, timeout sequences, and
// randomized traffic compared against a transaction-level reference model.
module tb_i2c_wb_arbiter;

    localparam logic [15:0] TCYC = 16'd16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] m0_adr_i = '0, m1_adr_i = '0, s_adr_o;
    logic [7:0] m0_dat_i = '0, m1_dat_i = '0, s_dat_o, s_dat_i = '0;
    logic [7:0] m0_dat_o, m1_dat_o;
    logic       m0_we_i = 0, m0_stb_i = 0, m0_cyc_i = 0, m0_ack_o;
    logic       m1_we_i = 0, m1_stb_i = 0, m1_cyc_i = 0, m1_ack_o;
    logic       s_we_o, s_stb_o, s_cyc_o, s_ack_i = 0;
    logic [1:0] grant;
    logic       timeout;

    always #5 clk = ~clk;

    i2c_wb_arbiter #(.TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
        .grant(grant), .timeout(timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, c0, s0, c1, s1, a);
        @(negedge clk);
        rst = r; m0_cyc_i = c0; m0_stb_i = s0; m1_cyc_i = c1; m1_stb_i = s1; s_ack_i = a;
    endtask

    task automatic hs(input string name, input logic c0, s0, c1, s1, a,
                      input logic [1:0] eg, input logic et);
        drive(1'b0, c0, s0, c1, s1, a);
        #1;
        check({name, " grant"}, grant, eg);
        check({name, " timeout"}, timeout, et);
    endtask

    typedef struct {
        logic       r, c0, s0, c1, s1, ack;
        logic [2:0] adr0;
        logic [7:0] dat0;
        logic [1:0] g;
        logic       scyc, sstb, a0, a1, tmo;
    } vec_t;

    vec_t tbl [27];

    // Reference model: owner is -1 when nobody holds the bus.
    int   mdl_owner, mdl_last, mdl_idle;
    bit   mdl_gap, mdl_tmo;
    bit   mdl_blk [2];

    task automatic model_step(input bit r, input bit c[2], input bit s[2], input bit a);
        if (r) begin
            mdl_owner = -1; mdl_gap = 0; mdl_last = 1; mdl_idle = 0; mdl_tmo = 0;
            mdl_blk[0] = 0; mdl_blk[1] = 0;
            return;
        end
        mdl_tmo = 0;
        for (int n = 0; n < 2; n++) if (!c[n]) mdl_blk[n] = 0;
        if (mdl_owner >= 0) begin
            if (!c[mdl_owner]) begin
                mdl_last = mdl_owner; mdl_owner = -1; mdl_gap = 1;
            end else if (s[mdl_owner] || a) begin
                mdl_idle = 0;
            end else if (mdl_idle + 1 == int'(TCYC)) begin
                mdl_tmo = 1; mdl_blk[mdl_owner] = 1; mdl_last = mdl_owner;
                mdl_owner = -1; mdl_gap = 1;
            end else begin
                mdl_idle++;
            end
        end else if (mdl_gap) begin
            mdl_gap = 0;
        end else begin
            bit e0, e1;
            e0 = c[0] && !mdl_blk[0];
            e1 = c[1] && !mdl_blk[1];
            if (e0 && e1) mdl_owner = 1 - mdl_last;
            else if (e0)  mdl_owner = 0;
            else if (e1)  mdl_owner = 1;
            mdl_idle = 0;
        end
    endtask

    bit          rc [2];
    bit          rs [2];
    bit          ra, rr, quiet;
    logic [1:0]  eg;
    logic [13:0] es;
    logic [17:0] em;

    initial begin
        tbl[0]  = '{1,0,0,0,0,0, 3'd0, 8'h00, 2'b00, 0,0,0,0,0};
        tbl[1]  = '{1,1,1,0,0,0, 3'd6, 8'h4B, 2'b00, 0,0,0,0,0};
        tbl[2]  = '{0,1,0,0,0,0, 3'd6, 8'h4B, 2'b00, 0,0,0,0,0};
        tbl[3]  = '{0,1,1,0,0,0, 3'd6, 8'h4B, 2'b01, 1,1,0,0,0};
        tbl[4]  = '{0,1,1,0,0,1, 3'd6, 8'h4B, 2'b01, 1,1,1,0,0};
        tbl[5]  = '{0,1,1,0,0,0, 3'd7, 8'h00, 2'b01, 1,1,0,0,0};
        tbl[6]  = '{0,1,1,0,0,1, 3'd7, 8'h00, 2'b01, 1,1,1,0,0};
        tbl[7]  = '{0,0,0,0,0,0, 3'd7, 8'h00, 2'b01, 0,0,0,0,0};
        tbl[8]  = '{0,0,0,0,0,0, 3'd0, 8'h00, 2'b00, 0,0,0,0,0};
        tbl[9]  = '{0,0,0,0,0,1, 3'd0, 8'h00, 2'b00, 0,0,0,0,0};
        tbl[10] = '{1,0,0,0,0,0, 3'd0, 8'h00, 2'b00, 0,0,0,0,0};
        tbl[11] = '{0,1,0,1,0,0, 3'd3, 8'h03, 2'b00, 0,0,0,0,0};
        tbl[12] = '{0,1,0,1,1,0, 3'd3, 8'h03, 2'b01, 1,0,0,0,0};
        tbl[13] = '{0,1,1,1,1,1, 3'd3, 8'h03, 2'b01, 1,1,1,0,0};
        tbl[14] = '{0,0,0,1,1,0, 3'd3, 8'h03, 2'b01, 0,0,0,0,0};
        tbl[15] = '{0,0,0,1,0,0, 3'd0, 8'h00, 2'b00, 0,0,0,0,0};
        tbl[16] = '{0,0,0,1,0,0, 3'd0, 8'h00, 2'b00, 0,0,0,0,0};
        tbl[17] = '{0,1,0,1,1,1, 3'd0, 8'h00, 2'b10, 1,1,0,1,0};
        tbl[18] = '{0,1,0,0,0,0, 3'd0, 8'h00, 2'b10, 0,0,0,0,0};
        tbl[19] = '{0,1,0,1,0,0, 3'd0, 8'h00, 2'b00, 0,0,0,0,0};
        tbl[20] = '{0,1,0,1,0,0, 3'd0, 8'h00, 2'b00, 0,0,0,0,0};
        tbl[21] = '{0,1,1,1,0,0, 3'd3, 8'h03, 2'b01, 1,1,0,0,0};
        tbl[22] = '{1,1,1,1,0,0, 3'd3, 8'h03, 2'b00, 0,0,0,0,0};
        tbl[23] = '{0,1,1,1,0,0, 3'd3, 8'h03, 2'b00, 0,0,0,0,0};
        tbl[24] = '{0,1,0,1,0,0, 3'd3, 8'h03, 2'b01, 1,0,0,0,0};
        tbl[25] = '{0,0,0,0,0,0, 3'd3, 8'h03, 2'b01, 0,0,0,0,0};
        tbl[26] = '{0,0,0,0,0,0, 3'd0, 8'h00, 2'b00, 0,0,0,0,0};

        m0_we_i = 1'b1; m1_adr_i = 3'd5; m1_dat_i = 8'hA5; s_dat_i = 8'h3C;
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].r, tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack);
            m0_adr_i = tbl[i].adr0;
            m0_dat_i = tbl[i].dat0;
            #1;
            check($sformatf("row%0d grant", i), grant, tbl[i].g);
            check($sformatf("row%0d s_cyc", i), s_cyc_o, tbl[i].scyc);
            check($sformatf("row%0d s_stb", i), s_stb_o, tbl[i].sstb);
            check($sformatf("row%0d m0_ack", i), m0_ack_o, tbl[i].a0);
            check($sformatf("row%0d m1_ack", i), m1_ack_o, tbl[i].a1);
            check($sformatf("row%0d timeout", i), timeout, tbl[i].tmo);
            if (tbl[i].g == 2'b01) begin
                check($sformatf("row%0d s_adr", i), s_adr_o, tbl[i].adr0);
                check($sformatf("row%0d s_dat", i), s_dat_o, tbl[i].dat0);
                check($sformatf("row%0d m0_dat", i), m0_dat_o, 8'h3C);
                check($sformatf("row%0d m1_dat", i), m1_dat_o, 8'h00);
            end else if (tbl[i].g == 2'b10) begin
                check($sformatf("row%0d s_adr", i), s_adr_o, 3'd5);
                check($sformatf("row%0d s_dat", i), s_dat_o, 8'hA5);
                check($sformatf("row%0d m1_dat", i), m1_dat_o, 8'h3C);
            end
        end

        // Hung port 1: revoked after TCYC idle cycles, kept out until cyc drops.
        hs("to_req", 0,0,1,0,0, 2'b00, 0);
        hs("to_first", 0,0,1,1,1, 2'b10, 0);
        for (int i = 1; i <= 16; i++) hs($sformatf("to_idle%0d", i), 0,0,1,0,0, 2'b10, 0);
        hs("to_pulse", 0,0,1,0,0, 2'b00, 1);
        for (int i = 0; i < 5; i++) hs($sformatf("to_blocked%0d", i), 0,0,1,0,0, 2'b00, 0);
        hs("p0_req", 1,0,1,0,0, 2'b00, 0);
        hs("p0_own", 1,0,1,0,0, 2'b01, 0);
        hs("p0_drop", 0,0,1,0,0, 2'b01, 0);
        for (int i = 0; i < 4; i++) hs($sformatf("p1_still_blocked%0d", i), 0,0,1,0,0, 2'b00, 0);
        hs("p1_drop", 0,0,0,0,0, 2'b00, 0);
        hs("p1_rereq", 0,0,1,0,0, 2'b00, 0);
        hs("p1_regrant", 0,0,1,1,0, 2'b10, 0);

        // Ack on the limit cycle wins over the timeout and restarts the count.
        for (int i = 1; i <= 15; i++) hs($sformatf("lim_idle%0d", i), 0,0,1,0,0, 2'b10, 0);
        hs("lim_ack", 0,0,1,0,1, 2'b10, 0);
        check("lim_ack m1_ack", m1_ack_o, 1'b1);
        for (int i = 1; i <= 16; i++) hs($sformatf("lim_after%0d", i), 0,0,1,0,0, 2'b10, 0);
        hs("lim_pulse", 0,0,1,0,0, 2'b00, 1);
        hs("lim_release", 0,0,0,0,0, 2'b00, 0);

        // Randomized traffic against the reference model, starting from reset.
        rc[0] = 0; rc[1] = 0; quiet = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rr = (cyc == 0) || ($urandom_range(599) == 0);
            if ($urandom_range(39) == 0) rc[0] = !rc[0];
            if ($urandom_range(39) == 0) rc[1] = !rc[1];
            if ($urandom_range(29) == 0) quiet = !quiet;
            rs[0] = !quiet && ($urandom_range(3) == 0);
            rs[1] = !quiet && ($urandom_range(3) == 0);
            ra    = !quiet && ($urandom_range(5) == 0);
            drive(rr, rc[0], rs[0], rc[1], rs[1], ra);
            m0_adr_i = 3'($urandom); m0_dat_i = 8'($urandom); m0_we_i = 1'($urandom);
            m1_adr_i = 3'($urandom); m1_dat_i = 8'($urandom); m1_we_i = 1'($urandom);
            s_dat_i  = 8'($urandom);
            #1;
            if (cyc > 0) begin
                eg = 2'b00; es = '0; em = '0;
                if (!rr && mdl_owner == 0) begin
                    eg = 2'b01;
                    es = {m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i, m0_cyc_i};
                    em = {1'b0, 8'h00, s_ack_i, s_dat_i};
                end else if (!rr && mdl_owner == 1) begin
                    eg = 2'b10;
                    es = {m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i, m1_cyc_i};
                    em = {s_ack_i, s_dat_i, 1'b0, 8'h00};
                end
                check($sformatf("rnd%0d grant", cyc), grant, eg);
                check($sformatf("rnd%0d timeout", cyc), timeout, mdl_tmo);
                check($sformatf("rnd%0d core_bus", cyc),
                      {s_adr_o, s_dat_o, s_we_o, s_stb_o, s_cyc_o}, es);
                check($sformatf("rnd%0d req_side", cyc),
                      {m1_ack_o, m1_dat_o, m0_ack_o, m0_dat_o}, em);
            end
            model_step(rr, rc, rs, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_wb_arbiter.md
Name: i2c_wb_arbiter

Overview:
- Shares the single wishbone register port of the I2C master core between two requesters: port 0 is the CPU-driven I2C main controller; port 1 is a background sensor poller.
- Grants whole transactions: a grant is held while the winner keeps cyc high.
- Uses round-robin priority between the two ports.
- Revokes a hung grant after a programmable idle timeout.

Parameters:
- TIMEOUT_CYC, 16'd4096: consecutive granted cycles with neither s_stb_o nor s_ack_i high before the grant is revoked.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_adr_i  in  3  requester 0 register address
- m0_dat_i  in  8  requester 0 write data
- m0_dat_o  out  8  read data to requester 0
- m0_we_i  in  1  requester 0 write enable
- m0_stb_i  in  1  requester 0 strobe
- m0_cyc_i  in  1  requester 0 cycle/bus request
- m0_ack_o  out  1  ack to requester 0
- m1_adr_i, m1_dat_i, m1_dat_o, m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o: same as m0_*, for requester 1
- s_adr_o  out  3  address to I2C master core
- s_dat_o  out  8  write data to core
- s_dat_i  in  8  read data from core
- s_we_o  out  1  write enable to core
- s_stb_o  out  1  strobe to core
- s_cyc_o  out  1  cycle to core
- s_ack_i  in  1  ack from core
- grant  out  2  one-hot current owner; 2'b00 = none
- timeout  out  1  one-cycle pulse when a grant is revoked by the timeout

Behaviour:
- Reset: state=IDLE, grant=00, last_owner=1 (so port 0 wins first), block0=block1=0, counter=0, timeout=0.
- Outputs during reset and whenever grant=00: all s_* outputs, m*_ack_o and m*_dat_o are 0.
- State register: IDLE, OWN0, OWN1, GAP. grant is decoded from state (OWN0 -> 01, OWN1 -> 10).
- Eligibility: port n is eligible when mn_cyc_i=1 and blockn=0.
- IDLE:
  - Only one port eligible: go to OWNn.
  - Both eligible: go to the port that is not last_owner.
  - Otherwise stay in IDLE.
  - Arbitration takes 1 cycle: cyc seen at edge k, grant visible after edge k.
- OWNn datapath (combinational, zero latency):
  - s_adr_o/s_dat_o/s_we_o/s_stb_o/s_cyc_o = mn_* inputs.
  - mn_ack_o = s_ack_i and mn_dat_o = s_dat_i.
  - The other port sees ack=0 and dat=0. Its stb is ignored and never reaches the core.
- OWNn exit: on mn_cyc_i=0, set last_owner=n and go to GAP. A strobe issued in that same cycle is forwarded with cyc=0 and has no effect on the core.
- GAP: exactly one cycle with s_cyc_o=0, then IDLE. Back-to-back handovers therefore cost 2 idle cycles.
- Timeout counter (16 bit):
  - Cleared on entry to OWNn, and on any OWNn cycle where s_stb_o=1 or s_ack_i=1.
  - Otherwise increments in OWNn; holds at 0 outside OWNn.
  - When the counter equals TIMEOUT_CYC-1 and the cycle is idle: timeout=1 for one cycle, blockn=1, last_owner=n, go to GAP.
- blockn clears the first cycle mn_cyc_i=0 is seen, in any state. This stops a hung requester from being re-granted until it drops cyc.
- Simultaneous events:
  - Ack arriving in the same cycle as the timeout limit: the ack wins (counter clears, no revoke).
  - Ack arriving in the GAP/IDLE state: dropped, not routed to either port.
- Reset mid-transaction: immediate return to reset values at the next edge. s_cyc_o falls that edge. The core's in-flight I2C operation is not stopped by this block; the requester must issue cmd_stop after reset.
- No priority inversion: in OWNn, requests from the other port are held until the grant is released.

Test Plan:
- Port 0 alone writes prescale (adr 6, dat 8'h4B, then adr 7, dat 8'h00) -> grant=01 one cycle after m0_cyc_i; core sees both writes unchanged; m1_ack_o stays 0.
- Both cyc raised at the same edge after reset -> grant=01. Port 0 drops cyc -> GAP 1 cycle -> grant=10. Both raise again -> port 0 is granted next (round-robin).
- Port 0 mid-transaction (adr 3, dat 8'h03), port 1 raises cyc and pulses stb -> port 1's stb never appears on s_stb_o; grant stays 01 until m0_cyc_i=0.
- TIMEOUT_CYC=16; port 1 granted, holds cyc, core never acks -> timeout pulses 16 cycles after the last stb/ack; grant goes to 00. Port 1 is not regranted while cyc stays 1. Port 0 requesting is then granted. Port 1 drops and raises cyc -> eligible again.
- Ack at exactly the limit cycle -> no timeout, counter reset; stray s_ack_i=1 in IDLE -> both m*_ack_o stay 0.
- rst=1 while port 0 is in OWN0 with stb=1 -> next edge: grant=00, s_cyc_o=0, s_stb_o=0, timeout=0; after rst=0, both requesting -> port 0 granted first.
